pcie_ltssm_ctrl: RTL and testbench

//  Simplified PCIe link training and status state machine (LTSSM) for the pcie_controller.
//  - Sequences the PHY through receiver detect, polling, configuration and L0.
//  - Tells the TX ordered-set generator what to send, counts received ordered sets and reports link-up.
//  - Sits between pcie_controller and the TX/RX ordered-set datapaths.

---
 rtl/pcie_ltssm_ctrl_if.sv | 19 +
 rtl/pcie_ltssm_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_pcie_ltssm_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_ltssm_ctrl_if.sv
// Ordered-set channel between the LTSSM and the TX/RX ordered-set datapaths.
// master = LTSSM side, slave = datapath side.
interface pcie_ltssm_ctrl_if;
  logic       tx_os_valid_o;
  logic [1:0] tx_os_type_o;
  logic       tx_os_ready_i;
  logic       rx_os_valid_i;
  logic [1:0] rx_os_type_i;

  modport master (
    output tx_os_valid_o, tx_os_type_o,
    input  tx_os_ready_i, rx_os_valid_i, rx_os_type_i
  );

  modport slave (
    input  tx_os_valid_o, tx_os_type_o,
    output tx_os_ready_i, rx_os_valid_i, rx_os_type_i
  );
endinterface

// File: rtl/pcie_ltssm_ctrl.sv
// Simplified PCIe LTSSM: detect, polling, configuration, L0, recovery.
// Define PCIE_LTSSM_STATS_EN to add recov_cnt_o / tmo_cnt_o statistics.
module pcie_ltssm_ctrl #(
  parameter int QUIET_CYC   = 1000,
  parameter int TIMEOUT_CYC = 24000,
  parameter int TS1_TX_MIN  = 1024,
  parameter int TS2_TX_MIN  = 16,
  parameter int RX_OS_MIN   = 8,
  parameter int IDLE_TX_MIN = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       link_disable_i,
  input  logic       retrain_i,
  input  logic       rx_elec_idle_i,
  input  logic       rx_det_done_i,
  input  logic       rx_det_present_i,
  pcie_ltssm_ctrl_if.master os,
  output logic       tx_elec_idle_o,
  output logic       tx_det_req_o,
  output logic       link_up_o,
`ifdef PCIE_LTSSM_STATS_EN
  output logic [7:0] recov_cnt_o,
  output logic [7:0] tmo_cnt_o,
`endif
  output logic [2:0] ltssm_state_o
);

  localparam int CW = 16;
  localparam logic [1:0] OS_IDLE = 2'b00;
  localparam logic [1:0] OS_TS1  = 2'b01;
  localparam logic [1:0] OS_TS2  = 2'b10;

  typedef enum logic [2:0] {
    DQUIET   = 3'd0,
    DACTIVE  = 3'd1,
    POLL_ACT = 3'd2,
    POLL_CFG = 3'd3,
    CONFIG   = 3'd4,
    L0       = 3'd5,
    RECOVERY = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic            ts2_seen_q, ts2_seen_d;
  logic            tx_os_valid_q, tx_os_valid_d;
  logic [1:0]      tx_os_type_q, tx_os_type_d;
  logic            tx_elec_idle_q, tx_elec_idle_d;
  logic            tx_det_req_q, tx_det_req_d;
  logic            link_up_q, link_up_d;
  logic            rx_want, rx_other, tx_inc, timeout, entry;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    rx_want = 1'b0;
    unique case (state_q)
      POLL_ACT, RECOVERY:
        rx_want = os.rx_os_valid_i &
                  (os.rx_os_type_i == OS_TS1 || os.rx_os_type_i == OS_TS2);
      POLL_CFG: rx_want = os.rx_os_valid_i && os.rx_os_type_i == OS_TS2;
      CONFIG:   rx_want = os.rx_os_valid_i && os.rx_os_type_i == OS_IDLE;
      default:  rx_want = 1'b0;
    endcase
    rx_other = os.rx_os_valid_i & ~rx_want;
    // TS2s only count toward the POLL_CFG minimum once the partner sent one
    tx_inc   = tx_os_valid_q & os.tx_os_ready_i &
               (state_q != POLL_CFG || ts2_seen_q);
    timeout  = timer_q == CW'(TIMEOUT_CYC - 1);

    state_d = state_q;
    unique case (state_q)
      DQUIET:
        if (timer_q == CW'(QUIET_CYC - 1) || !rx_elec_idle_i)
          state_d = DACTIVE;
      DACTIVE:
        if (rx_det_done_i)
          state_d = rx_det_present_i ? POLL_ACT : DQUIET;
      POLL_ACT:
        if (tx_cnt_q >= CW'(TS1_TX_MIN) && rx_cnt_q >= CW'(RX_OS_MIN))
          state_d = POLL_CFG;
        else if (timeout)
          state_d = DQUIET;
      POLL_CFG:
        if (rx_cnt_q >= CW'(RX_OS_MIN) && tx_cnt_q >= CW'(TS2_TX_MIN))
          state_d = CONFIG;
        else if (timeout)
          state_d = DQUIET;
      CONFIG:
        if (rx_cnt_q >= CW'(RX_OS_MIN) && tx_cnt_q >= CW'(IDLE_TX_MIN))
          state_d = L0;
        else if (timeout)
          state_d = DQUIET;
      L0:
        if (retrain_i || (os.rx_os_valid_i && os.rx_os_type_i == OS_TS1))
          state_d = RECOVERY;
      RECOVERY:
        if (rx_cnt_q >= CW'(RX_OS_MIN))
          state_d = CONFIG;
        else if (timeout)
          state_d = DQUIET;
      default: state_d = DQUIET;
    endcase
    if (link_disable_i)
      state_d = DQUIET;

    entry = (state_d != state_q) || link_disable_i;
    if (entry) begin
      timer_d    = '0;
      tx_cnt_d   = '0;
      rx_cnt_d   = '0;
      ts2_seen_d = 1'b0;
    end else begin
      timer_d    = sat_inc(timer_q);
      tx_cnt_d   = tx_inc ? sat_inc(tx_cnt_q) : tx_cnt_q;
      rx_cnt_d   = rx_want ? sat_inc(rx_cnt_q) :
                   rx_other ? '0 : rx_cnt_q;
      ts2_seen_d = ts2_seen_q | (state_q == POLL_CFG && rx_want);
    end

    tx_os_valid_d  = 1'b0;
    tx_os_type_d   = OS_IDLE;
    tx_elec_idle_d = 1'b1;
    tx_det_req_d   = 1'b0;
    link_up_d      = 1'b0;
    unique case (state_d)
      DACTIVE: tx_det_req_d = state_q != DACTIVE;
      POLL_ACT, RECOVERY: begin
        tx_os_valid_d  = 1'b1;
        tx_os_type_d   = OS_TS1;
        tx_elec_idle_d = 1'b0;
      end
      POLL_CFG: begin
        tx_os_valid_d  = 1'b1;
        tx_os_type_d   = OS_TS2;
        tx_elec_idle_d = 1'b0;
      end
      CONFIG: begin
        tx_os_valid_d  = 1'b1;
        tx_elec_idle_d = 1'b0;
      end
      L0: begin
        link_up_d      = 1'b1;
        tx_elec_idle_d = 1'b0;
      end
      default: tx_elec_idle_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= DQUIET;
      timer_q        <= '0;
      tx_cnt_q       <= '0;
      rx_cnt_q       <= '0;
      ts2_seen_q     <= 1'b0;
      tx_os_valid_q  <= 1'b0;
      tx_os_type_q   <= OS_IDLE;
      tx_elec_idle_q <= 1'b1;
      tx_det_req_q   <= 1'b0;
      link_up_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      tx_cnt_q       <= tx_cnt_d;
      rx_cnt_q       <= rx_cnt_d;
      ts2_seen_q     <= ts2_seen_d;
      tx_os_valid_q  <= tx_os_valid_d;
      tx_os_type_q   <= tx_os_type_d;
      tx_elec_idle_q <= tx_elec_idle_d;
      tx_det_req_q   <= tx_det_req_d;
      link_up_q      <= link_up_d;
    end
  end

  assign os.tx_os_valid_o = tx_os_valid_q;
  assign os.tx_os_type_o  = tx_os_type_q;
  assign tx_elec_idle_o   = tx_elec_idle_q;
  assign tx_det_req_o     = tx_det_req_q;
  assign link_up_o        = link_up_q;
  assign ltssm_state_o    = state_q;

`ifdef PCIE_LTSSM_STATS_EN
  logic [7:0] recov_cnt_q, recov_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       tmo_hit, recov_hit;

  always_comb begin
    // a timed state falling to DQUIET without disable can only be a timeout
    tmo_hit   = !link_disable_i && state_d == DQUIET &&
                (state_q == POLL_ACT || state_q == POLL_CFG ||
                 state_q == CONFIG || state_q == RECOVERY);
    recov_hit = state_q == L0 && state_d == RECOVERY;
    tmo_cnt_d   = (tmo_hit && tmo_cnt_q != 8'hff) ?
                  tmo_cnt_q + 8'd1 : tmo_cnt_q;
    recov_cnt_d = (recov_hit && recov_cnt_q != 8'hff) ?
                  recov_cnt_q + 8'd1 : recov_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      recov_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      recov_cnt_q <= recov_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign recov_cnt_o = recov_cnt_q;
  assign tmo_cnt_o   = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_pcie_ltssm_ctrl.sv
// Directed bench for pcie_ltssm_ctrl with shortened training parameters.
// Works with and without PCIE_LTSSM_STATS_EN.
module tb_pcie_ltssm_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       link_disable, retrain, rx_elec_idle;
  logic       det_done, det_present;
  logic       tx_elec_idle, tx_det_req, link_up;
  logic [2:0] state;
`ifdef PCIE_LTSSM_STATS_EN
  logic [7:0] recov_cnt, tmo_cnt;
`endif
  int checks = 0;
  int errors = 0;

  pcie_ltssm_ctrl_if os();

  pcie_ltssm_ctrl #(
    .QUIET_CYC(10), .TIMEOUT_CYC(200), .TS1_TX_MIN(16),
    .TS2_TX_MIN(4), .RX_OS_MIN(8), .IDLE_TX_MIN(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .link_disable_i(link_disable),
    .retrain_i(retrain),
    .rx_elec_idle_i(rx_elec_idle),
    .rx_det_done_i(det_done),
    .rx_det_present_i(det_present),
    .os(os),
    .tx_elec_idle_o(tx_elec_idle),
    .tx_det_req_o(tx_det_req),
    .link_up_o(link_up),
`ifdef PCIE_LTSSM_STATS_EN
    .recov_cnt_o(recov_cnt),
    .tmo_cnt_o(tmo_cnt),
`endif
    .ltssm_state_o(state)
  );

  always #5 clk = ~clk;

  task automatic check_reset_vals(input string tag);
    checks++;
    if (state !== 3'd0 || os.tx_os_valid_o !== 1'b0 ||
        os.tx_os_type_o !== 2'b00 || tx_elec_idle !== 1'b1 ||
        tx_det_req !== 1'b0 || link_up !== 1'b0) begin
      errors++;
      $display("FAIL %s: st=%0d v=%b t=%b ei=%b det=%b up=%b req 0 0 00 1 0 0",
               tag, state, os.tx_os_valid_o, os.tx_os_type_o,
               tx_elec_idle, tx_det_req, link_up);
    end
`ifdef PCIE_LTSSM_STATS_EN
    checks++;
    if (recov_cnt !== 8'd0 || tmo_cnt !== 8'd0) begin
      errors++;
      $display("FAIL %s_stats: recov=%0d tmo=%0d req 0 0",
               tag, recov_cnt, tmo_cnt);
    end
`endif
  endtask

  // drive rx type while in state s; check how many cycles it lasts
  task automatic run_phase(input logic [2:0] s, input logic [1:0] ty,
                           input int exp_len, input string tag);
    int n = 0;
    os.rx_os_valid_i = 1'b1;
    os.rx_os_type_i  = ty;
    while (state === s && n < 300) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== exp_len) begin
      errors++;
      $display("FAIL %s_len: got %0d cycles req %0d", tag, n, exp_len);
    end
    os.rx_os_valid_i = 1'b0;
  endtask

  task automatic goto_poll_act();
    int n = 0;
    while (state !== 3'd1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    det_done = 1'b1;
    det_present = 1'b1;
    @(negedge clk);
    det_done = 1'b0;
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL goto_poll_act: state %0d req 2", state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    link_disable = 0; retrain = 0; rx_elec_idle = 1;
    det_done = 0; det_present = 0;
    os.tx_os_ready_i = 1; os.rx_os_valid_i = 0; os.rx_os_type_i = 2'b00;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_detect();
    int n = 0;
    while (state === 3'd0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL quiet_len: got %0d req 10", n);
    end
    checks++;
    if (state !== 3'd1 || tx_det_req !== 1'b1) begin
      errors++;
      $display("FAIL det_req_on: st=%0d det=%b req 1 1", state, tx_det_req);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || tx_det_req !== 1'b0) begin
      errors++;
      $display("FAIL det_req_off: st=%0d det=%b req 1 0", state, tx_det_req);
    end
    det_done = 1'b1;
    det_present = 1'b0;
    @(negedge clk);
    det_done = 1'b0;
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL det_absent: state %0d req 0", state);
    end
  endtask

  task automatic test_train();
    goto_poll_act();
    checks++;
    if (os.tx_os_valid_o !== 1'b1 || os.tx_os_type_o !== 2'b01) begin
      errors++;
      $display("FAIL poll_act_tx: v=%b t=%b req 1 01",
               os.tx_os_valid_o, os.tx_os_type_o);
    end
    run_phase(3'd2, 2'b01, 17, "poll_act");
    checks++;
    if (state !== 3'd3 || os.tx_os_type_o !== 2'b10) begin
      errors++;
      $display("FAIL poll_cfg: st=%0d t=%b req 3 10", state, os.tx_os_type_o);
    end
    run_phase(3'd3, 2'b10, 9, "poll_cfg");
    checks++;
    if (state !== 3'd4 || os.tx_os_type_o !== 2'b00 || os.tx_os_valid_o !== 1) begin
      errors++;
      $display("FAIL config: st=%0d t=%b v=%b req 4 00 1",
               state, os.tx_os_type_o, os.tx_os_valid_o);
    end
    run_phase(3'd4, 2'b00, 9, "config");
    checks++;
    if (state !== 3'd5 || link_up !== 1'b1 || os.tx_os_valid_o !== 1'b0 ||
        tx_elec_idle !== 1'b0) begin
      errors++;
      $display("FAIL l0: st=%0d up=%b v=%b ei=%b req 5 1 0 0",
               state, link_up, os.tx_os_valid_o, tx_elec_idle);
    end
  endtask

  task automatic test_retrain();
    retrain = 1'b1;
    @(negedge clk);
    retrain = 1'b0;
    checks++;
    if (state !== 3'd6 || os.tx_os_valid_o !== 1'b1 ||
        os.tx_os_type_o !== 2'b01 || link_up !== 1'b0) begin
      errors++;
      $display("FAIL recovery: st=%0d v=%b t=%b up=%b req 6 1 01 0",
               state, os.tx_os_valid_o, os.tx_os_type_o, link_up);
    end
    run_phase(3'd6, 2'b10, 9, "recovery");
    run_phase(3'd4, 2'b00, 9, "re_config");
    checks++;
    if (state !== 3'd5 || link_up !== 1'b1) begin
      errors++;
      $display("FAIL re_l0: st=%0d up=%b req 5 1", state, link_up);
    end
`ifdef PCIE_LTSSM_STATS_EN
    checks++;
    if (recov_cnt !== 8'd1) begin
      errors++;
      $display("FAIL recov_cnt: got %0d req 1", recov_cnt);
    end
`endif
  endtask

  task automatic test_timeout();
    int n = 0;
    link_disable = 1'b1;
    @(negedge clk);
    link_disable = 1'b0;
    checks++;
    if (state !== 3'd0 || link_up !== 1'b0) begin
      errors++;
      $display("FAIL disable_l0: st=%0d up=%b req 0 0", state, link_up);
    end
    goto_poll_act();
    while (state === 3'd2 && n < 400) begin
      os.rx_os_valid_i = n < 15;
      os.rx_os_type_i  = (n == 7) ? 2'b11 : 2'b01;
      n++;
      @(negedge clk);
    end
    os.rx_os_valid_i = 1'b0;
    checks++;
    if (n !== 200 || state !== 3'd0) begin
      errors++;
      $display("FAIL timeout: %0d cycles st=%0d req 200 0", n, state);
    end
`ifdef PCIE_LTSSM_STATS_EN
    checks++;
    if (tmo_cnt !== 8'd1) begin
      errors++;
      $display("FAIL tmo_cnt: got %0d req 1", tmo_cnt);
    end
`endif
  endtask

  task automatic test_ready_stall();
    int bad = 0;
    goto_poll_act();
    run_phase(3'd2, 2'b01, 17, "stall_poll_act");
    os.tx_os_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state !== 3'd3 || os.tx_os_valid_o !== 1'b1 ||
          os.tx_os_type_o !== 2'b10)
        bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_hold: %0d bad cycles req 0", bad);
    end
    link_disable = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || os.tx_os_valid_o !== 1'b0 || tx_elec_idle !== 1'b1) begin
      errors++;
      $display("FAIL stall_disable: st=%0d v=%b ei=%b req 0 0 1",
               state, os.tx_os_valid_o, tx_elec_idle);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL disable_hold: state %0d req 0", state);
    end
    link_disable = 1'b0;
    os.tx_os_ready_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    goto_poll_act();
    run_phase(3'd2, 2'b01, 17, "rst_poll_act");
    run_phase(3'd3, 2'b10, 9, "rst_poll_cfg");
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL rst_in_config: state %0d req 4", state);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    while (state === 3'd0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 10 || state !== 3'd1) begin
      errors++;
      $display("FAIL restart: %0d quiet cycles st=%0d req 10 1", n, state);
    end
  endtask

  initial begin
    test_reset();
    test_detect();
    test_train();
    test_retrain();
    test_timeout();
    test_ready_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
